// File: rtl/matrix_bram_pkg.sv
// Shared definitions for the matrix storage BRAM. The storage manager
// (writer) and the storage reader both import this package so that slot
// layout and header format are defined in one place.
//
// Slot layout (BLOCK_SIZE words per slot):
//   word 0 : {rows[31:24], cols[23:16], 16'h0}
//   word 1 : name bytes 0..3 (byte 0 in [31:24])
//   word 2 : name bytes 4..7
//   word 3+: row-major element words
package matrix_bram_pkg;

    localparam int BLOCK_SIZE   = 1152;
    localparam int HEADER_WORDS = 3;
    localparam int HDR_DIM_ADDR = 0;
    localparam int HDR_NAME_HI  = 1;
    localparam int HDR_NAME_LO  = 2;
    localparam int MAX_DIM      = 32;

    typedef enum logic [2:0] {
        RD_IDLE,
        RD_HDR,
        RD_ERR,
        RD_FETCH,
        RD_OUT,
        RD_DONE
    } rd_state_e;

    // First word address of a slot. The caller truncates to its address width.
    function automatic int unsigned slot_base(input logic [2:0] id,
                                              input int unsigned blk = BLOCK_SIZE);
        return {29'd0, id} * blk;
    endfunction

endpackage

// File: rtl/bram_word_fetch.sv
// Single-word BRAM fetch unit.
// Registers an address into the storage read port on `issue` and counts
// READ_LATENCY cycles with a valid shift register. `word_valid` is high in
// the cycle whose closing edge is the capture edge (issue edge +
// READ_LATENCY); the consumer registers `word_data` on that edge.
// `busy` covers the whole flight including the capture cycle, so a new
// address can never overtake an outstanding capture.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   issue, issue_addr     start a fetch (ignored by design contract when busy)
//   bram_addr             registered BRAM read address
//   bram_data             BRAM read data
//   busy                  a fetch is in flight
//   word_valid, word_data capture strobe and the word to capture
module bram_word_fetch #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 14,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue,
    input  logic [ADDR_WIDTH-1:0] issue_addr,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    input  logic [DATA_WIDTH-1:0] bram_data,
    output logic                  busy,
    output logic                  word_valid,
    output logic [DATA_WIDTH-1:0] word_data
);

    // vld_pipe[k] set means k edges have passed since the address was issued.
    logic [READ_LATENCY:1] vld_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bram_addr <= '0;
            vld_pipe  <= '0;
        end else begin
            if (issue) bram_addr <= issue_addr;
            vld_pipe[1] <= issue;
            for (int k = 2; k <= READ_LATENCY; k++) vld_pipe[k] <= vld_pipe[k-1];
        end
    end

    assign busy       = |vld_pipe;
    assign word_valid = vld_pipe[READ_LATENCY];
    assign word_data  = bram_data;

endmodule

// File: rtl/matrix_storage_reader.sv
// Matrix storage reader.
// On an accepted read_request, fetches the 3-word header of slot matrix_id,
// validates the dimensions, then streams rows*cols element words over a
// valid/ready interface, one fetch per element.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   read_request/read_ready     start pulse / idle indication
//   matrix_id                   slot index, sampled on accept
//   bram_addr/bram_data         storage read port
//   actual_rows/cols, matrix_name, header_valid   decoded header
//   data_out/valid/ready/last   element stream
//   read_done/read_error        completion / illegal-header pulses
module matrix_storage_reader #(
    parameter int BLOCK_SIZE   = matrix_bram_pkg::BLOCK_SIZE,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 14,
    parameter int READ_LATENCY = 2,
    parameter int MAX_DIM      = matrix_bram_pkg::MAX_DIM
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  read_request,
    output logic                  read_ready,
    input  logic [2:0]            matrix_id,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    input  logic [DATA_WIDTH-1:0] bram_data,
    output logic [7:0]            actual_rows,
    output logic [7:0]            actual_cols,
    output logic [7:0]            matrix_name [0:7],
    output logic                  header_valid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  data_last,
    output logic                  read_done,
    output logic                  read_error
);

    import matrix_bram_pkg::*;

    rd_state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0] base_q;
    logic [1:0]            hdr_issued;   // header words already addressed
    logic [15:0]           count_q;
    logic [15:0]           idx_q;

    logic                  issue;
    logic [ADDR_WIDTH-1:0] issue_addr;
    logic                  busy;
    logic                  word_valid;
    logic [DATA_WIDTH-1:0] word_data;

    logic hdr_check;
    logic hdr_bad;

    bram_word_fetch #(
        .DATA_WIDTH  (DATA_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .READ_LATENCY(READ_LATENCY)
    ) u_fetch (
        .clk       (clk),
        .rst_n     (rst_n),
        .issue     (issue),
        .issue_addr(issue_addr),
        .bram_addr (bram_addr),
        .bram_data (bram_data),
        .busy      (busy),
        .word_valid(word_valid),
        .word_data (word_data)
    );

    // All three header words are addressed and the last one has landed.
    assign hdr_check = (state_q == RD_HDR) && !busy && (hdr_issued == 2'd3);
    assign hdr_bad   = (actual_rows == 8'd0) || (actual_cols == 8'd0) ||
                       (actual_rows > 8'(MAX_DIM)) || (actual_cols > 8'(MAX_DIM));

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RD_IDLE;
        else        state_q <= state_d;
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RD_IDLE:  if (read_request) state_d = RD_HDR;
            RD_HDR:   if (hdr_check) state_d = hdr_bad ? RD_ERR : RD_FETCH;
            RD_ERR:   state_d = RD_IDLE;
            RD_FETCH: if (word_valid) state_d = RD_OUT;
            RD_OUT:   if (data_ready) state_d = data_last ? RD_DONE : RD_FETCH;
            RD_DONE:  state_d = RD_IDLE;
            default:  state_d = RD_IDLE;
        endcase
    end

    // ---------------- outputs / fetch control ----------------
    always_comb begin
        read_ready = (state_q == RD_IDLE);
        read_error = (state_q == RD_ERR);
        read_done  = (state_q == RD_DONE);
        issue      = 1'b0;
        issue_addr = base_q;
        unique case (state_q)
            RD_IDLE: begin
                issue      = read_request;
                issue_addr = ADDR_WIDTH'(slot_base(matrix_id, BLOCK_SIZE));
            end
            RD_HDR: begin
                issue      = !busy && (hdr_issued != 2'd3);
                issue_addr = base_q + ADDR_WIDTH'(hdr_issued);
            end
            RD_FETCH: begin
                // busy stays high through the capture cycle, so this issues
                // exactly once per element
                issue      = !busy;
                issue_addr = base_q + ADDR_WIDTH'(HEADER_WORDS) + ADDR_WIDTH'(idx_q);
            end
            default: ;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q       <= '0;
            hdr_issued   <= '0;
            count_q      <= '0;
            idx_q        <= '0;
            actual_rows  <= '0;
            actual_cols  <= '0;
            header_valid <= 1'b0;
            data_out     <= '0;
            data_valid   <= 1'b0;
            data_last    <= 1'b0;
            for (int b = 0; b < 8; b++) matrix_name[b] <= 8'h00;
        end else begin
            header_valid <= 1'b0;

            if (state_q == RD_IDLE && read_request) begin
                base_q     <= issue_addr;
                hdr_issued <= 2'd1;
            end

            if (state_q == RD_HDR) begin
                if (issue) hdr_issued <= hdr_issued + 2'd1;
                // one word in flight, so the landing word is the last one addressed
                if (word_valid) begin
                    unique case (hdr_issued - 2'd1)
                        2'(HDR_DIM_ADDR): begin
                            actual_rows <= word_data[31:24];
                            actual_cols <= word_data[23:16];
                        end
                        2'(HDR_NAME_HI):
                            for (int b = 0; b < 4; b++) matrix_name[b] <= word_data[31-8*b -: 8];
                        2'(HDR_NAME_LO):
                            for (int b = 0; b < 4; b++) matrix_name[4+b] <= word_data[31-8*b -: 8];
                        default: ;
                    endcase
                end
                if (hdr_check && !hdr_bad) begin
                    header_valid <= 1'b1;
                    count_q      <= 16'(actual_rows) * 16'(actual_cols);
                    idx_q        <= '0;
                end
            end

            if (state_q == RD_FETCH && word_valid) begin
                data_out   <= word_data;
                data_valid <= 1'b1;
                data_last  <= (idx_q == count_q - 16'd1);
            end

            if (state_q == RD_OUT && data_ready) begin
                data_valid <= 1'b0;
                data_last  <= 1'b0;
                idx_q      <= idx_q + 16'd1;
            end
        end
    end

endmodule
